rr_arb4_mux_sched: RTL and testbench
====================================

Name: rr_arb4_mux_sched

Overview:
- Round-robin scheduler that shares one 4:1 multiplexer among four requesters.
- Each requester raises req while it needs the shared path. The block grants exactly one owner at a time and drives the 2-bit select of the downstream 4:1 mux to that owner.
- Sits directly in front of the mux select input. Enforces fairness and a bounded hold time.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; any other value is an elaboration error.
- MAX_HOLD, 8, maximum consecutive cycles an owner keeps the grant while others wait. 0 = unlimited (no preemption).
- HCNT_W, $clog2(MAX_HOLD+1) (min 1), hold-counter width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  per-requester request; level, held high while access is wanted
- gnt  output 4  one-hot grant, registered; all-zero when idle
- sel  output 2  binary index of current owner; drives mux select; registered
- busy  output 1  high while any grant is active (gnt != 0)
- timeout  output 1  single-cycle pulse on the cycle a grant is preempted by MAX_HOLD

Behaviour:
- Reset (rst=1 at a clock edge) takes priority over everything, including mid-grant. Resulting values:
  - gnt=0, sel=0, busy=0, timeout=0
  - state=IDLE, ptr=0, hold_cnt=0
- State machine:
  - IDLE: no owner.
  - GRANT: one owner; owner = sel.
- Round-robin search:
  - Scan req starting at index ptr, then ptr+1 ... wrapping mod 4.
  - The first set bit wins.
  - ptr updates to winner+1 (mod 4) on every new grant.
- IDLE behaviour:
  - If req != 0: go to GRANT next edge; gnt=onehot(winner), sel=winner, hold_cnt=1.
  - Latency from req high to gnt high is 1 clock.
- GRANT, owner drops its req:
  - If another req is set: hand off at the next edge to the round-robin winner from ptr. No idle bubble; hold_cnt=1.
  - Otherwise: go to IDLE; gnt=0, busy=0, sel holds its last value.
- GRANT, owner keeps req and MAX_HOLD=0 or hold_cnt<MAX_HOLD: stay; hold_cnt increments.
- GRANT, owner keeps req and hold_cnt==MAX_HOLD (MAX_HOLD>0):
  - If any other req is set: preempt. The grant moves next edge to the winner (search excludes the current owner). timeout=1 for exactly that edge's cycle; hold_cnt=1.
  - If no other req is set: the owner keeps the grant, hold_cnt restarts at 1, and timeout stays 0.
- The counter never exceeds MAX_HOLD; no wrap-around is possible.
- gnt always changes directly from one one-hot value to another; never two bits set.
- sel always equals the encoded gnt whenever busy=1.
- Simultaneous events:
  - Owner release and hold expiry on the same cycle: treat as a release. No timeout pulse.
  - New requests arriving during a grant only affect the next arbitration.
- Requests that drop before being granted are forgotten; no request latching.

Decomposition:
- Package mux_arb_pkg holds:
  - NREQ=4, SEL_W=2
  - state enum {IDLE, GRANT}
  - function onehot4(idx)
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], ptr[1:0], excl_en, excl_idx.
  - Outputs: any, win[1:0].
  - Implements the rotate-and-priority search, with optional exclusion of the current owner for preemption.
- The top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Single request: reset, then req=0010 → one edge later gnt=0010, sel=1, busy=1, timeout=0. Drop req → next edge gnt=0000, busy=0, sel stays 1.
- Fair rotation: from reset req=1111; each owner drops its req bit for 1 cycle after 2 granted cycles, then re-raises → grant order 0,1,2,3,0 with direct handoffs (busy never drops).
- Preemption (MAX_HOLD=8): req=0011 held constant → gnt=0001 for 8 cycles, timeout pulse 1 cycle, gnt=0010 for 8 cycles, timeout pulse, back to 0001.
- No preemption when alone: req=0100 held 20 cycles with MAX_HOLD=8 → gnt=0100 continuously, timeout never asserts.
- Release coincides with expiry: owner 0 drops req on its 8th cycle while req[1]=1 → handoff to 0010, timeout stays 0.
- Reset mid-operation: during an owner-2 grant assert rst for 1 cycle → next edge gnt=0, sel=0, ptr=0. Then req=1001 → gnt=0001.

Source files
------------

// File: rtl/rr_arb4_mux_sched_pkg.sv
// mux_arb_pkg: shared constants, FSM state type and the one-hot helper for
// the 4-requester round-robin mux scheduler.
//   NREQ    : number of requesters (fixed at 4)
//   SEL_W   : width of the downstream mux select
//   state_t : scheduler state (IDLE = no owner, GRANT = one owner)
//   onehot4 : binary index -> one-hot grant vector
package mux_arb_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
      onehot4      = '0;
      onehot4[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_arb4_mux_sched_if.sv
// rr_arb4_mux_sched_if: request/grant bundle between the requesters and the
// scheduler.
//   req     : per-requester level request        (requesters -> scheduler)
//   gnt     : one-hot grant, all-zero when idle  (scheduler -> requesters)
//   sel     : binary owner index for the mux     (scheduler -> mux)
//   busy    : any grant active
//   timeout : one-cycle pulse when a grant is preempted by the hold limit
// Modports: master = requester side, slave = scheduler side.
interface rr_arb4_mux_sched_if;
   import mux_arb_pkg::*;

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  gnt;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             timeout;

   modport master (output req, input gnt, sel, busy, timeout);
   modport slave  (input req, output gnt, sel, busy, timeout);

endinterface

// File: rtl/rr_arb4_mux_sched_pick4.sv
// rr_pick4: combinational rotate-and-priority search over four requests.
//   i_req      : request vector
//   i_ptr      : index where the search starts (highest priority)
//   i_excl_en  : drop i_excl_idx from the search (used for preemption)
//   i_excl_idx : index to exclude
//   o_any      : some eligible request found
//   o_win      : index of the first eligible request at or after i_ptr
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NREQ-1:0]  i_req,
   input  logic [SEL_W-1:0] i_ptr,
   input  logic             i_excl_en,
   input  logic [SEL_W-1:0] i_excl_idx,
   output logic             o_any,
   output logic [SEL_W-1:0] o_win
);

   logic [SEL_W-1:0] w_idx;

   // Walk ptr, ptr+1, ... with natural 2-bit wrap; first hit wins.
   always_comb begin
      o_any = 1'b0;
      o_win = i_ptr;
      w_idx = i_ptr;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = i_ptr + SEL_W'(i);
         if (!o_any && i_req[w_idx] && !(i_excl_en && (w_idx == i_excl_idx))) begin
            o_any = 1'b1;
            o_win = w_idx;
         end
      end
   end

endmodule

// File: rtl/rr_arb4_mux_sched.sv
// rr_arb4_mux_sched: round-robin owner scheduler in front of a shared 4:1 mux.
// Grants one requester at a time, rotates priority on every new grant and
// preempts an owner that has held the path for MAX_HOLD cycles while others
// wait (MAX_HOLD = 0 disables preemption).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : scheduler side of rr_arb4_mux_sched_if (req in; gnt/sel/busy/timeout out)
module rr_arb4_mux_sched #(
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   rr_arb4_mux_sched_if.slave    bus
);
   import mux_arb_pkg::*;

   localparam int HCNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(MAX_HOLD);
   localparam logic [HCNT_W-1:0] HOLD_ONE = HCNT_W'(1);

   if (NREQ != 4) begin : g_bad_nreq
      $error("rr_arb4_mux_sched: NREQ must be 4");
   end

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_gnt, w_gnt_nxt;
   logic [SEL_W-1:0]  r_sel, w_sel_nxt;
   logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
   logic [HCNT_W-1:0] r_hold, w_hold_nxt;
   logic              r_timeout, w_timeout_nxt;

   logic              w_keep;
   logic              w_expire;
   logic              w_excl;
   logic              w_any;
   logic [SEL_W-1:0]  w_win;
   logic              w_new;

   // Owner still wants the path / has used up its hold budget.
   assign w_keep   = bus.req[r_sel];
   assign w_expire = (MAX_HOLD != 0) && (r_hold == HOLD_MAX);
   // Only exclude the owner when it would otherwise be re-picked on expiry;
   // on a release its req bit is already low.
   assign w_excl   = (r_state == GRANT) && w_keep && w_expire;

   rr_pick4 u_pick (
      .i_req      (bus.req),
      .i_ptr      (r_ptr),
      .i_excl_en  (w_excl),
      .i_excl_idx (r_sel),
      .o_any      (w_any),
      .o_win      (w_win)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_sel     <= '0;
         r_ptr     <= '0;
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_sel     <= w_sel_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hold    <= w_hold_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // Next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_nxt = GRANT;
         GRANT:   if (!w_keep && !w_any) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Next grant / select / pointer / hold counter / timeout
   always_comb begin
      w_gnt_nxt     = r_gnt;
      w_sel_nxt     = r_sel;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold;
      w_timeout_nxt = 1'b0;
      w_new         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) w_new = 1'b1;
         end
         GRANT: begin
            if (!w_keep) begin
               // Release wins over a coincident expiry: no timeout pulse.
               if (w_any) begin
                  w_new = 1'b1;
               end else begin
                  w_gnt_nxt  = '0;
                  w_hold_nxt = '0;
               end
            end else if (!w_expire) begin
               // Unlimited hold parks the counter instead of letting it wrap.
               if (MAX_HOLD != 0) w_hold_nxt = r_hold + HOLD_ONE;
            end else if (w_any) begin
               w_new         = 1'b1;
               w_timeout_nxt = 1'b1;
            end else begin
               // Nobody waiting: owner keeps the path, budget restarts.
               w_hold_nxt = HOLD_ONE;
            end
         end
         default: ;
      endcase
      if (w_new) begin
         w_gnt_nxt  = onehot4(w_win);
         w_sel_nxt  = w_win;
         w_ptr_nxt  = w_win + SEL_W'(1);
         w_hold_nxt = HOLD_ONE;
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.sel     = r_sel;
   assign bus.busy    = |r_gnt;
   assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_arb4_mux_sched.sv
// Directed bench for rr_arb4_mux_sched (MAX_HOLD = 8). Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_rr_arb4_mux_sched;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rr_arb4_mux_sched_if bus ();

   rr_arb4_mux_sched #(.NREQ(4), .MAX_HOLD(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      bus.req = 4'b0000;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_gnt", 8'(bus.gnt), 8'h0);
      chk("rst_sel", 8'(bus.sel), 8'h0);
      chk("rst_busy", 8'(bus.busy), 8'h0);
      chk("rst_timeout", 8'(bus.timeout), 8'h0);

      // Single request: one-cycle latency, release to idle keeps sel
      bus.req = 4'b0010;
      step();
      chk("single_gnt", 8'(bus.gnt), 8'h02);
      chk("single_sel", 8'(bus.sel), 8'h1);
      chk("single_busy", 8'(bus.busy), 8'h1);
      chk("single_to", 8'(bus.timeout), 8'h0);
      bus.req = 4'b0000;
      step();
      chk("release_gnt", 8'(bus.gnt), 8'h0);
      chk("release_busy", 8'(bus.busy), 8'h0);
      chk("release_sel", 8'(bus.sel), 8'h1);

      // Fair rotation with direct handoffs: 0,1,2,3,0
      do_reset();
      bus.req = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         chk("rot_gnt_a", 8'(bus.gnt), 8'(4'b0001 << (k % 4)));
         chk("rot_busy_a", 8'(bus.busy), 8'h1);
         step();
         chk("rot_gnt_b", 8'(bus.gnt), 8'(4'b0001 << (k % 4)));
         chk("rot_busy_b", 8'(bus.busy), 8'h1);
         if (k < 4) begin
            bus.req = 4'b1111 & ~(4'b0001 << (k % 4));
            step();
            bus.req = 4'b1111;
         end
      end

      // Preemption after 8 cycles, both directions
      do_reset();
      bus.req = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("pre_own0", 8'(bus.gnt), 8'h01);
         chk("pre_own0_to", 8'(bus.timeout), 8'h0);
      end
      step();
      chk("pre_to1_gnt", 8'(bus.gnt), 8'h02);
      chk("pre_to1_pulse", 8'(bus.timeout), 8'h1);
      chk("pre_to1_sel", 8'(bus.sel), 8'h1);
      for (int c = 0; c < 7; c++) begin
         step();
         chk("pre_own1", 8'(bus.gnt), 8'h02);
         chk("pre_own1_to", 8'(bus.timeout), 8'h0);
      end
      step();
      chk("pre_to2_gnt", 8'(bus.gnt), 8'h01);
      chk("pre_to2_pulse", 8'(bus.timeout), 8'h1);
      step();
      chk("pre_after_gnt", 8'(bus.gnt), 8'h01);
      chk("pre_after_to", 8'(bus.timeout), 8'h0);

      // Lone owner is never preempted
      do_reset();
      bus.req = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("alone_gnt", 8'(bus.gnt), 8'h04);
         chk("alone_to", 8'(bus.timeout), 8'h0);
      end

      // Release on the 8th cycle counts as release, not timeout
      do_reset();
      bus.req = 4'b0011;
      for (int c = 0; c < 8; c++) step();
      chk("coin_own0", 8'(bus.gnt), 8'h01);
      bus.req = 4'b0010;
      step();
      chk("coin_gnt", 8'(bus.gnt), 8'h02);
      chk("coin_to", 8'(bus.timeout), 8'h0);
      chk("coin_busy", 8'(bus.busy), 8'h1);

      // Reset mid-grant clears grant, select and pointer
      do_reset();
      bus.req = 4'b0100;
      step();
      chk("mid_gnt", 8'(bus.gnt), 8'h04);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_gnt", 8'(bus.gnt), 8'h0);
      chk("mid_rst_sel", 8'(bus.sel), 8'h0);
      chk("mid_rst_busy", 8'(bus.busy), 8'h0);
      bus.req = 4'b1001;
      step();
      chk("mid_ptr_gnt", 8'(bus.gnt), 8'h01);
      chk("mid_ptr_sel", 8'(bus.sel), 8'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
